// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/memory stages, mem_arbiter and the shared mem_system.
// The arbiter takes the slave view; the pipeline and memory side take the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_done;
  logic        if_stall;

  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;

  logic        halt;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_dump;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_err;

  logic        err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done, mem_stall, mem_err,
    output if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump, err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt,
           mem_rdata, mem_done, mem_stall, mem_err,
    input  if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall,
           mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch port and the data port: one transaction at a time,
// round-robin on contention, hang detection, and a createdump pulse on HALT.
module mem_arbiter #(
  parameter int unsigned TIMEOUT    = 64,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_I, S_WAIT_D, S_RESP_I, S_RESP_D, S_DUMP, S_ERR
  } state_t;

  typedef enum logic {PORT_FETCH, PORT_DATA} port_t;

  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  port_t         r_last_grant;
  logic [CW-1:0] r_cnt;
  logic          r_wr_op;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic [15:0]   r_if_data;
  logic [15:0]   r_dm_rdata;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_mem_dump;

  logic          w_dm_req;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_dump;
  logic          w_hang;
  logic          w_if_done;
  logic          w_dm_done;

  assign w_dm_req = io_bus.dm_rd | io_bus.dm_wr;
  assign w_hang   = io_bus.mem_err | (~io_bus.mem_done & (r_cnt == CNT_MAX));

  // Grants and the dump request are only ever decided in IDLE; halt wins over new requests.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_dump    = 1'b0;
    if (r_state == S_IDLE) begin
      if (io_bus.halt) begin
        w_dump = 1'b1;
      end else if (!io_bus.mem_stall) begin
        if (io_bus.if_req && w_dm_req) begin
          w_grant_d = (r_last_grant == PORT_FETCH);
          w_grant_i = (r_last_grant == PORT_DATA);
        end else begin
          w_grant_i = io_bus.if_req;
          w_grant_d = w_dm_req;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if      (w_dump)    w_next = S_DUMP;
        else if (w_grant_d) w_next = S_WAIT_D;
        else if (w_grant_i) w_next = S_WAIT_I;
      end
      S_WAIT_I: begin
        if      (w_hang)          w_next = S_ERR;
        else if (io_bus.mem_done) w_next = S_RESP_I;
      end
      S_WAIT_D: begin
        if      (w_hang)          w_next = S_ERR;
        else if (io_bus.mem_done) w_next = S_RESP_D;
      end
      S_RESP_I, S_RESP_D: w_next = S_IDLE;
      S_DUMP:             w_next = S_DUMP;
      S_ERR:              w_next = S_ERR;
      default:            w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= DATA_FIRST ? PORT_FETCH : PORT_DATA;
      r_cnt        <= '0;
      r_wr_op      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_data    <= '0;
      r_dm_rdata   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_dump   <= 1'b0;
    end else begin
      // Strobes are high only in the cycle right after the grant or dump decision.
      r_mem_rd   <= w_grant_i | (w_grant_d & ~io_bus.dm_wr);
      r_mem_wr   <= w_grant_d & io_bus.dm_wr;
      r_mem_dump <= w_dump;

      if (w_grant_i) begin
        r_mem_addr <= io_bus.if_addr;
      end
      if (w_grant_d) begin
        r_mem_addr  <= io_bus.dm_addr;
        r_mem_wdata <= io_bus.dm_wdata;
        r_wr_op     <= io_bus.dm_wr;
      end
      if (io_bus.if_req && w_dm_req && (w_grant_i || w_grant_d)) begin
        r_last_grant <= w_grant_d ? PORT_DATA : PORT_FETCH;
      end

      if (w_grant_i || w_grant_d)                      r_cnt <= '0;
      else if (r_state == S_WAIT_I || r_state == S_WAIT_D) r_cnt <= r_cnt + CW'(1);

      if (w_next == S_RESP_I)             r_if_data  <= io_bus.mem_rdata;
      if (w_next == S_RESP_D && !r_wr_op) r_dm_rdata <= io_bus.mem_rdata;
    end
  end

  always_comb begin
    w_if_done        = (r_state == S_RESP_I);
    w_dm_done        = (r_state == S_RESP_D);
    io_bus.if_done   = w_if_done;
    io_bus.dm_done   = w_dm_done;
    io_bus.if_stall  = io_bus.if_req & ~w_if_done;
    io_bus.dm_stall  = w_dm_req & ~w_dm_done;
    io_bus.err       = (r_state == S_ERR);
    io_bus.if_data   = r_if_data;
    io_bus.dm_rdata  = r_dm_rdata;
    io_bus.mem_addr  = r_mem_addr;
    io_bus.mem_wdata = r_mem_wdata;
    io_bus.mem_rd    = r_mem_rd;
    io_bus.mem_wr    = r_mem_wr;
    io_bus.mem_dump  = r_mem_dump;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural mem_system plus a scoreboard of expected
// grants and completions, filled when requests are driven and drained by a monitor.
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } grant_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(64), .DATA_FIRST(1'b1)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  grant_t      exp_grants[$];
  logic [15:0] exp_if[$];
  logic [15:0] exp_dm[$];
  logic [15:0] shadow [logic [15:0]];
  logic [15:0] mem_store [logic [15:0]];
  logic [15:0] exp_dm_last = '0;
  int          lat  = 3;
  bit          hang = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] expect_rd(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : pattern(a);
  endfunction

  // Behavioural mem_system: Done arrives lat cycles after the Rd/Wr strobe, DataOut is junk otherwise.
  initial begin : mem_model
    int          cd;
    logic [15:0] rd_val;
    cd = 0;
    rd_val = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 16'hF00D;
    forever begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (rst === 1'b1) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) bus.mem_done = 1'b1;
      end
      bus.mem_rdata = bus.mem_done ? rd_val : 16'hF00D;
      if (rst !== 1'b1 && (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1)) begin
        if (bus.mem_wr === 1'b1) begin
          mem_store[bus.mem_addr] = bus.mem_wdata;
          rd_val = 16'hDEAD;
        end else begin
          rd_val = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : pattern(bus.mem_addr);
        end
        cd = hang ? 0 : lat;
      end
    end
  end

  initial begin : monitor
    grant_t e;
    logic   prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
        if (exp_grants.size() == 0) begin
          check("spurious_grant", {bus.mem_wr, bus.mem_rd}, 2'b00);
        end else begin
          e = exp_grants.pop_front();
          check("grant_kind", {bus.mem_wr, bus.mem_rd}, {e.wr, ~e.wr});
          check("grant_addr", bus.mem_addr, e.addr);
          if (e.wr) check("grant_wdata", bus.mem_wdata, e.wdata);
        end
        check("strobe_one_cycle", prev_busy, 1'b0);
      end
      prev_busy = (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1);
      if (bus.if_done === 1'b1) begin
        if (exp_if.size() == 0) check("spurious_if_done", bus.if_done, 1'b0);
        else                    check("if_data", bus.if_data, exp_if.pop_front());
      end
      if (bus.dm_done === 1'b1) begin
        if (exp_dm.size() == 0) check("spurious_dm_done", bus.dm_done, 1'b0);
        else                    check("dm_rdata", bus.dm_rdata, exp_dm.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    bus.halt = 1'b0; bus.mem_stall = 1'b0; bus.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_dm_last = '0;
  endtask

  task automatic issue_fetch(input logic [15:0] a, input bit expect_done);
    grant_t g;
    g.wr = 1'b0; g.addr = a; g.wdata = '0;
    exp_grants.push_back(g);
    if (expect_done) exp_if.push_back(expect_rd(a));
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic issue_data(input bit rd, input bit wr, input logic [15:0] a,
                            input logic [15:0] wd, input bit expect_done);
    grant_t g;
    g.wr = wr; g.addr = a; g.wdata = wd;
    exp_grants.push_back(g);
    if (wr) shadow[a] = wd;
    else if (expect_done) exp_dm_last = expect_rd(a);
    if (expect_done) exp_dm.push_back(exp_dm_last);
    bus.dm_rd = rd; bus.dm_wr = wr; bus.dm_addr = a; bus.dm_wdata = wd;
  endtask

  task automatic wait_done(input bit is_d, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? (bus.dm_done === 1'b1) : (bus.if_done === 1'b1);
    end
    check({tag, "_done"}, seen, 1'b1);
    if (is_d) begin bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; end
    else      bus.if_req = 1'b0;
  endtask

  initial begin : stimulus
    int nd, ni;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.halt = 1'b0;
    bus.mem_stall = 1'b0; bus.mem_err = 1'b0;

    // Reset state
    do_reset();
    check("rst_mem_rd",   bus.mem_rd,   1'b0);
    check("rst_mem_wr",   bus.mem_wr,   1'b0);
    check("rst_mem_dump", bus.mem_dump, 1'b0);
    check("rst_err",      bus.err,      1'b0);
    check("rst_dones",    {bus.if_done, bus.dm_done}, 2'b00);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);
    check("rst_if_data",  bus.if_data,  16'h0000);

    // 1: single fetch, done three cycles after the strobe
    lat = 3;
    issue_fetch(16'h0010, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("t1_mem_rd",   bus.mem_rd,   (i == 1));
      check("t1_if_done",  bus.if_done,  (i == 5));
      check("t1_if_stall", bus.if_stall, (i < 5));
      if (i == 5) bus.if_req = 1'b0;
    end

    // 2: write, read+write treated as write, read-back of the written word
    @(negedge clk); issue_data(1'b0, 1'b1, 16'h0100, 16'hBEEF, 1'b1); wait_done(1'b1, "t2_wr");
    @(negedge clk); issue_data(1'b1, 1'b1, 16'h0110, 16'h1234, 1'b1); wait_done(1'b1, "t2_rdwr");
    @(negedge clk); issue_data(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1); wait_done(1'b1, "t2_rd");

    // mem_stall holds off the grant until released
    @(negedge clk);
    bus.mem_stall = 1'b1;
    bus.dm_rd = 1'b1; bus.dm_addr = 16'h0A00;
    repeat (4) begin
      @(negedge clk);
      check("stall_dm_stall", bus.dm_stall, 1'b1);
    end
    issue_data(1'b1, 1'b0, 16'h0A00, 16'h0000, 1'b1);
    bus.mem_stall = 1'b0;
    wait_done(1'b1, "stall_rd");

    // 3: both ports held, grant order D,I,D,I from reset
    do_reset();
    issue_data(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1);
    issue_fetch(16'h0300, 1'b1);
    issue_data(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1);
    issue_fetch(16'h0300, 1'b1);
    nd = 0; ni = 0;
    for (int n = 0; n < 100 && (nd < 2 || ni < 2); n++) begin
      @(negedge clk);
      if (bus.dm_done === 1'b1) begin nd++; if (nd == 2) bus.dm_rd = 1'b0; end
      if (bus.if_done === 1'b1) begin ni++; if (ni == 2) bus.if_req = 1'b0; end
    end
    check("t3_dm_count", nd, 2);
    check("t3_if_count", ni, 2);

    // 4: hung data read times out after 64 WAIT cycles
    do_reset();
    hang = 1'b1;
    issue_data(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0);
    for (int i = 1; i <= 65; i++) begin
      @(negedge clk);
      if (i == 64) check("t4_err_before", bus.err, 1'b0);
      if (i == 65) check("t4_err_set",    bus.err, 1'b1);
    end
    bus.if_req = 1'b1; bus.if_addr = 16'h0444;
    repeat (10) @(negedge clk);
    check("t4_err_sticky", bus.err,      1'b1);
    check("t4_dm_stall",   bus.dm_stall, 1'b1);
    check("t4_if_stall",   bus.if_stall, 1'b1);
    hang = 1'b0;

    // 5: halt during WAIT_D: completion first, then a single dump pulse, fetch ignored
    do_reset();
    lat = 3;
    issue_data(1'b1, 1'b0, 16'h0500, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    bus.halt = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0600;
    wait_done(1'b1, "t5_rd");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t5_mem_dump", bus.mem_dump, (i == 2));
      check("t5_if_stall", bus.if_stall, 1'b1);
    end

    // 6: reset in the second WAIT_I cycle abandons the fetch
    do_reset();
    lat = 10;
    issue_fetch(16'h0700, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t6_mem_rd",   bus.mem_rd,   1'b0);
    check("t6_mem_addr", bus.mem_addr, 16'h0000);
    check("t6_if_data",  bus.if_data,  16'h0000);
    check("t6_flags",    {bus.if_done, bus.dm_done, bus.err, bus.mem_dump, bus.mem_wr}, 5'b0);
    check("t6_stalls",   {bus.if_stall, bus.dm_stall}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    exp_dm_last = '0;
    lat = 2;
    issue_fetch(16'h0800, 1'b1);
    wait_done(1'b0, "t6_refetch");

    // mem_err during WAIT_D goes straight to ERR
    do_reset();
    hang = 1'b1;
    issue_data(1'b1, 1'b0, 16'h0900, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    check("merr_err_before", bus.err, 1'b0);
    bus.mem_err = 1'b1;
    @(negedge clk);
    bus.mem_err = 1'b0;
    check("merr_err_set",  bus.err,      1'b1);
    check("merr_dm_stall", bus.dm_stall, 1'b1);
    hang = 1'b0;
    repeat (3) @(negedge clk);

    check("grants_drained", exp_grants.size(), 0);
    check("if_drained",     exp_if.size(),     0);
    check("dm_drained",     exp_dm.size(),     0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
